mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates between instruction-fetch and load/store requesters for the single shared byte-serial MemCtrl.
//  Sequences one task at a time: grant, issue, wait, complete.
//  Applies data-first priority, with an anti-starvation override for instruction fetch.
//  Drops results of instruction fetches and loads on rob_clear; in-flight stores always complete.
// PARAMETERS
//  ADDR_WIDTH    32  width of all address buses
//  STARVE_LIMIT  4   consecutive instruction losses before instruction fetch wins over data
//  CNT_WIDTH     3   width of the starvation counter (must hold STARVE_LIMIT)
// PORTS
//  clk_in        in   1   system clock (single clock)
//  rst_in        in   1   synchronous, active-high reset
//  rdy_in        in   1   low = pause; every register holds its value
//  rob_clear     in   1   pipeline flush
//  inst_req      in   1   instruction fetch request
//  inst_addr     in   32  fetch address
//  inst_grant    out  1   combinational; request accepted this cycle, requester may drop inst_req next cycle
//  inst_done     out  1   1-cycle pulse; inst_data valid
//  inst_data     out  32  fetched word
//  data_req      in   1   load/store request
//  data_is_write in   1   1 = store
//  data_addr     in   32  load/store address
//  data_wdata    in   32  store data
//  data_type     in   3   [2] signed, [1:0] 00 byte / 01 half / 10 word
//  data_grant    out  1   combinational accept
//  data_done     out  1   1-cycle pulse; data_rdata valid (loads)
//  data_rdata    out  32  load result (already extended by MemCtrl)
//  mc_start      out  1   1-cycle task strobe to MemCtrl
//  mc_is_write   out  1   latched data_is_write (0 for fetch)
//  mc_addr       out  32  latched address
//  mc_wdata      out  32  latched store data
//  mc_type       out  3   latched data_type; 3'b010 for fetch
//  mc_busy       in   1   MemCtrl working
//  mc_done       in   1   1-cycle completion pulse
//  mc_rdata      in   32  read result, valid with mc_done
// BEHAVIOUR
//  FSM states: IDLE, ISSUE, WAIT.
//  Reset: state=IDLE; all outputs, starve_cnt, cancel and owner registers = 0.
//  IDLE -> ISSUE (grant) when rdy_in && !rob_clear && !mc_busy && (inst_req || data_req).
//   - Winner is data, unless inst_req && starve_cnt >= STARVE_LIMIT; then inst wins.
//   - Exactly one grant asserts. The grant latches owner and the mc_* fields.
//  ISSUE: mc_start=1 for exactly one cycle, then -> WAIT.
//  WAIT: on mc_done -> IDLE. The owner's done pulse and data register next cycle.
//   - Latency: grant at cycle T, mc_start at T+1, done at (mc_done cycle)+1.
//   - A new grant is allowed in the same cycle done is pulsed.
//  starve_cnt:
//   - +1 (saturating) on each data grant while inst_req=1.
//   - Cleared on inst grant, or when inst_req=0 in IDLE.
//  rob_clear:
//   - In IDLE: no grant that cycle.
//   - In ISSUE/WAIT with owner=inst or load: set cancel. Task runs to mc_done (MemCtrl is never aborted by this block). Done is suppressed. cancel clears on return to IDLE.
//   - Owner=store: ignored; data_done still pulses.
//   - rob_clear in the same cycle as mc_done: suppression still applies.
//  rdy_in=0: state, counters and latched fields hold. Strobe outputs hold (not re-pulsed on resume).
//  mc_done in IDLE/ISSUE is a protocol violation: ignore it and flag it with a bench assertion.
//  Reset mid-task: back to IDLE immediately. No done is issued. MemCtrl is reset by the same rst_in.
// STRUCTURE
//  Config.v: work-type encodings (`WT_BYTE/HALF/WORD), FSM state encodings, owner encoding.
//  Sub-module mem_arb_pick: winner select plus starvation counter (combinational pick, registered count).
//  Top level: FSM, latch registers, done/cancel logic.
// TESTING
//  1. inst_req only, addr 0x100; mc_done 4 cycles after mc_start, mc_rdata=0x00000013
//     -> inst_grant at T, mc_start at T+1, inst_done with 0x13 one cycle after mc_done.
//  2. inst_req and data_req (load 0x2000) together -> data_grant first; inst granted once the load completes.
//  3. Both requesting, data_req re-asserted after every completion, STARVE_LIMIT=4
//     -> 4 data grants, then inst_grant; starve_cnt returns to 0.
//  4. Load to 0x3000 in WAIT, rob_clear pulse -> no data_done; back to IDLE after mc_done; next grant proceeds normally.
//  5. Store 0xDEADBEEF to 0x30000, rob_clear during WAIT
//     -> mc_wdata stays 0xDEADBEEF, data_done still pulses.
//  6. rdy_in low for 3 cycles in ISSUE -> mc_start held, no extra strobe; rst_in mid-WAIT -> IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory arbiter (work types, FSM states, task owner).
package mem_arbiter_pkg;

   // Low two bits of a work type select the access width; bit 2 requests sign extension.
   localparam logic [1:0] WT_BYTE = 2'b00;
   localparam logic [1:0] WT_HALF = 2'b01;
   localparam logic [1:0] WT_WORD = 2'b10;

   // Instruction fetches are always unsigned full-word reads.
   localparam logic [2:0] FETCH_TYPE = {1'b0, WT_WORD};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_INST,
      OWN_DATA
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: winner select between fetch and load/store, with a saturating starvation counter.
//  clk_in, rst_in, rdy_in : clock, sync active-high reset, global pause (low = hold)
//  idle_i                 : arbiter FSM is in IDLE
//  allow_i                : a grant may be issued this cycle
//  inst_req_i, data_req_i : requests
//  inst_grant_o, data_grant_o : combinational, mutually exclusive grants
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WIDTH    = 3
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic rdy_in,
   input  logic idle_i,
   input  logic allow_i,
   input  logic inst_req_i,
   input  logic data_req_i,
   output logic inst_grant_o,
   output logic data_grant_o
);

   localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 inst_win;

   // Data wins by default; a fetch that has lost LIMIT times in a row takes priority.
   always_comb begin
      inst_win     = inst_req_i && (!data_req_i || cnt_q >= LIMIT);
      inst_grant_o = allow_i && inst_win;
      data_grant_o = allow_i && data_req_i && !inst_win;
      cnt_d        = cnt_q;
      if (rdy_in) begin
         if (inst_grant_o || (idle_i && !inst_req_i))
            cnt_d = '0;
         else if (data_grant_o && inst_req_i && !(&cnt_q))
            cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and load/store tasks onto one shared MemCtrl.
//  clk_in, rst_in, rdy_in, rob_clear : clock, sync reset, pause, pipeline flush
//  inst_*  : fetch request/grant/done/data
//  data_*  : load/store request/grant/done/read data
//  mc_*    : task strobe and latched fields to MemCtrl; busy/done/rdata back from it
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_WIDTH    = 3
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  rob_clear,
   input  logic                  inst_req,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic                  inst_grant,
   output logic                  inst_done,
   output logic [31:0]           inst_data,
   input  logic                  data_req,
   input  logic                  data_is_write,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [31:0]           data_wdata,
   input  logic [2:0]            data_type,
   output logic                  data_grant,
   output logic                  data_done,
   output logic [31:0]           data_rdata,
   output logic                  mc_start,
   output logic                  mc_is_write,
   output logic [ADDR_WIDTH-1:0] mc_addr,
   output logic [31:0]           mc_wdata,
   output logic [2:0]            mc_type,
   input  logic                  mc_busy,
   input  logic                  mc_done,
   input  logic [31:0]           mc_rdata
);

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  cancel_q, cancel_d;
   logic                  is_write_q, is_write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [2:0]            type_q, type_d;
   logic                  inst_done_q, inst_done_d;
   logic                  data_done_q, data_done_d;
   logic [31:0]           inst_data_q, inst_data_d;
   logic [31:0]           data_rdata_q, data_rdata_d;
   logic                  allow, is_store, drop;

   assign allow    = state_q == ST_IDLE && rdy_in && !rob_clear && !mc_busy;
   assign is_store = owner_q == OWN_DATA && is_write_q;
   // Stores must always retire; everything else is discarded once a flush has been seen.
   assign drop     = !is_store && (cancel_q || rob_clear);

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .CNT_WIDTH   (CNT_WIDTH)
   ) u_pick (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .idle_i      (state_q == ST_IDLE),
      .allow_i     (allow),
      .inst_req_i  (inst_req),
      .data_req_i  (data_req),
      .inst_grant_o(inst_grant),
      .data_grant_o(data_grant)
   );

   // With rdy_in low every register, strobes included, keeps its value.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      cancel_d     = cancel_q;
      is_write_d   = is_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      type_d       = type_q;
      inst_done_d  = inst_done_q;
      data_done_d  = data_done_q;
      inst_data_d  = inst_data_q;
      data_rdata_d = data_rdata_q;
      if (rdy_in) begin
         inst_done_d = 1'b0;
         data_done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (inst_grant || data_grant) begin
                  state_d    = ST_ISSUE;
                  owner_d    = inst_grant ? OWN_INST : OWN_DATA;
                  is_write_d = data_grant && data_is_write;
                  addr_d     = inst_grant ? inst_addr : data_addr;
                  wdata_d    = data_grant ? data_wdata : wdata_q;
                  type_d     = inst_grant ? FETCH_TYPE : data_type;
               end
            end
            ST_ISSUE: begin
               state_d  = ST_WAIT;
               cancel_d = cancel_q || (rob_clear && !is_store);
            end
            ST_WAIT: begin
               cancel_d = cancel_q || (rob_clear && !is_store);
               if (mc_done) begin
                  state_d     = ST_IDLE;
                  owner_d     = OWN_NONE;
                  cancel_d    = 1'b0;
                  inst_done_d = owner_q == OWN_INST && !drop;
                  data_done_d = owner_q == OWN_DATA && !drop;
                  inst_data_d = inst_done_d ? mc_rdata : inst_data_q;
                  data_rdata_d = (data_done_d && !is_write_q) ? mc_rdata : data_rdata_q;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_NONE;
         cancel_q     <= 1'b0;
         is_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         type_q       <= '0;
         inst_done_q  <= 1'b0;
         data_done_q  <= 1'b0;
         inst_data_q  <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         cancel_q     <= cancel_d;
         is_write_q   <= is_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         type_q       <= type_d;
         inst_done_q  <= inst_done_d;
         data_done_q  <= data_done_d;
         inst_data_q  <= inst_data_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // The strobe is simply "in ISSUE", so a pause stretches it without re-pulsing.
   assign mc_start    = state_q == ST_ISSUE;
   assign mc_is_write = is_write_q;
   assign mc_addr     = addr_q;
   assign mc_wdata    = wdata_q;
   assign mc_type     = type_q;
   assign inst_done   = inst_done_q;
   assign inst_data   = inst_data_q;
   assign data_done   = data_done_q;
   assign data_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a small MemCtrl model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst_in = 1'b1, rdy_in = 1'b1, rob_clear = 1'b0;
   logic        inst_req = 1'b0, data_req = 1'b0, data_is_write = 1'b0;
   logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
   logic [2:0]  data_type = '0;
   logic        inst_grant, inst_done, data_grant, data_done;
   logic [31:0] inst_data, data_rdata;
   logic        mc_start, mc_is_write;
   logic [31:0] mc_addr, mc_wdata;
   logic [2:0]  mc_type;
   logic        mc_busy = 1'b0, mc_done = 1'b0;
   logic [31:0] mc_rdata = '0;

   int          tests = 0, fails = 0;
   int          mc_lat = 4;
   logic [31:0] mc_resp = '0;
   logic        active = 1'b0;
   int          cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_grant(inst_grant),
      .inst_done(inst_done), .inst_data(inst_data),
      .data_req(data_req), .data_is_write(data_is_write), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_type(data_type), .data_grant(data_grant),
      .data_done(data_done), .data_rdata(data_rdata),
      .mc_start(mc_start), .mc_is_write(mc_is_write), .mc_addr(mc_addr),
      .mc_wdata(mc_wdata), .mc_type(mc_type), .mc_busy(mc_busy),
      .mc_done(mc_done), .mc_rdata(mc_rdata)
   );

   // MemCtrl model: accepts a strobe, pulses mc_done mc_lat cycles after the strobe cycle.
   always @(posedge clk) begin
      if (rst_in) begin
         active   <= 1'b0;
         mc_busy  <= 1'b0;
         mc_done  <= 1'b0;
         mc_rdata <= '0;
         cnt      <= 0;
      end else if (rdy_in) begin
         mc_done <= 1'b0;
         if (active) begin
            if (cnt == 1) begin
               mc_done  <= 1'b1;
               mc_rdata <= mc_resp;
               active   <= 1'b0;
               mc_busy  <= 1'b0;
            end else cnt <= cnt - 1;
         end else if (mc_start) begin
            active  <= 1'b1;
            mc_busy <= 1'b1;
            cnt     <= mc_lat - 1;
         end
      end
   end

   always @(negedge clk)
      if (!rst_in)
         a_done_in_wait: assert (!mc_done || dut.state_q == ST_WAIT)
            else $error("FAIL mc_done_protocol state=%0d", dut.state_q);

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0;
      inst_req = 1'b0; data_req = 1'b0; data_is_write = 1'b0;
      inst_addr = '0; data_addr = '0; data_wdata = '0; data_type = '0;
      repeat (2) @(negedge clk);
      rst_in = 1'b0;
   endtask

   task automatic wait_mc_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mc_done && n < 60);
      if (!mc_done) begin
         tests++; fails++;
         $display("FAIL mc_done_timeout waited=%0d required<60", n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests++; if ({inst_grant, inst_done, data_grant, data_done, mc_start, mc_is_write} !== 6'b0) begin fails++; $display("FAIL reset_strobes got=%b exp=000000", {inst_grant, inst_done, data_grant, data_done, mc_start, mc_is_write}); end
      tests++; if ({mc_addr, mc_wdata, inst_data, data_rdata} !== 128'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", {mc_addr, mc_wdata, inst_data, data_rdata}); end
      tests++; if (mc_type !== 3'b000) begin fails++; $display("FAIL reset_type got=%b exp=000", mc_type); end
      tests++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
   endtask

   task automatic test_inst_only();
      int n;
      do_reset();
      mc_resp = 32'h13;
      inst_req = 1'b1; inst_addr = 32'h100;
      #1;
      tests++; if ({inst_grant, data_grant} !== 2'b10) begin fails++; $display("FAIL inst_only_grant got=%b exp=10", {inst_grant, data_grant}); end
      @(negedge clk);
      inst_req = 1'b0;
      #1;
      tests++; if (mc_start !== 1'b1) begin fails++; $display("FAIL inst_only_start got=%b exp=1", mc_start); end
      tests++; if ({mc_addr, mc_type, mc_is_write} !== {32'h100, 3'b010, 1'b0}) begin fails++; $display("FAIL inst_only_fields got=%h/%b/%b exp=100/010/0", mc_addr, mc_type, mc_is_write); end
      wait_mc_done(n);
      tests++; if (n !== 4) begin fails++; $display("FAIL inst_only_latency got=%0d exp=4", n); end
      @(negedge clk); #1;
      tests++; if ({inst_done, data_done} !== 2'b10) begin fails++; $display("FAIL inst_only_done got=%b exp=10", {inst_done, data_done}); end
      tests++; if (inst_data !== 32'h13) begin fails++; $display("FAIL inst_only_data got=%h exp=00000013", inst_data); end
      @(negedge clk); #1;
      tests++; if (inst_done !== 1'b0) begin fails++; $display("FAIL inst_only_pulse got=%b exp=0", inst_done); end
   endtask

   task automatic test_data_first();
      int n;
      do_reset();
      mc_resp = 32'h11223344;
      inst_req = 1'b1; inst_addr = 32'h200;
      data_req = 1'b1; data_is_write = 1'b0; data_addr = 32'h2000; data_type = 3'b110;
      #1;
      tests++; if ({inst_grant, data_grant} !== 2'b01) begin fails++; $display("FAIL data_first_grant got=%b exp=01", {inst_grant, data_grant}); end
      @(negedge clk);
      data_req = 1'b0;
      #1;
      tests++; if ({mc_addr, mc_type, mc_is_write} !== {32'h2000, 3'b110, 1'b0}) begin fails++; $display("FAIL data_first_fields got=%h/%b/%b exp=2000/110/0", mc_addr, mc_type, mc_is_write); end
      wait_mc_done(n);
      @(negedge clk); #1;
      tests++; if ({data_done, data_rdata} !== {1'b1, 32'h11223344}) begin fails++; $display("FAIL data_first_load got=%b/%h exp=1/11223344", data_done, data_rdata); end
      tests++; if (inst_grant !== 1'b1) begin fails++; $display("FAIL data_first_inst_next got=%b exp=1", inst_grant); end
      @(negedge clk);
      inst_req = 1'b0; mc_resp = 32'h55;
      #1;
      tests++; if ({mc_start, mc_addr, mc_type} !== {1'b1, 32'h200, 3'b010}) begin fails++; $display("FAIL data_first_inst_issue got=%b/%h/%b exp=1/200/010", mc_start, mc_addr, mc_type); end
      wait_mc_done(n);
      @(negedge clk); #1;
      tests++; if ({inst_done, inst_data} !== {1'b1, 32'h55}) begin fails++; $display("FAIL data_first_inst_done got=%b/%h exp=1/55", inst_done, inst_data); end
   endtask

   task automatic test_starvation();
      int n, k;
      logic [1:0] exp;
      do_reset();
      mc_resp = 32'h0;
      inst_req = 1'b1; inst_addr = 32'h300;
      data_req = 1'b1; data_is_write = 1'b0; data_addr = 32'h4000; data_type = 3'b010;
      for (int g = 0; g < 5; g++) begin
         k = 0;
         if (g > 0) @(negedge clk);
         #1;
         while (!(inst_grant || data_grant) && k < 60) begin
            @(negedge clk); #1; k++;
         end
         exp = (g == 4) ? 2'b10 : 2'b01;
         tests++; if ({inst_grant, data_grant} !== exp) begin fails++; $display("FAIL starve_grant%0d got=%b exp=%b", g, {inst_grant, data_grant}, exp); end
         if (g == 4) begin
            tests++; if (dut.u_pick.cnt_q !== 3'd4) begin fails++; $display("FAIL starve_cnt_full got=%0d exp=4", dut.u_pick.cnt_q); end
         end
      end
      @(negedge clk);
      inst_req = 1'b0; data_req = 1'b0;
      #1;
      tests++; if (dut.u_pick.cnt_q !== 3'd0) begin fails++; $display("FAIL starve_cnt_clear got=%0d exp=0", dut.u_pick.cnt_q); end
      tests++; if ({mc_addr, mc_type} !== {32'h300, 3'b010}) begin fails++; $display("FAIL starve_inst_fields got=%h/%b exp=300/010", mc_addr, mc_type); end
      wait_mc_done(n);
      @(negedge clk);
   endtask

   task automatic test_rob_clear_load();
      int n;
      do_reset();
      inst_req = 1'b1; inst_addr = 32'h500; rob_clear = 1'b1;
      #1;
      tests++; if ({inst_grant, data_grant} !== 2'b00) begin fails++; $display("FAIL flush_idle_grant got=%b exp=00", {inst_grant, data_grant}); end
      @(negedge clk);
      rob_clear = 1'b0; inst_req = 1'b0;
      data_req = 1'b1; data_is_write = 1'b0; data_addr = 32'h3000; data_type = 3'b000; mc_resp = 32'hAA;
      #1;
      tests++; if (data_grant !== 1'b1) begin fails++; $display("FAIL flush_load_grant got=%b exp=1", data_grant); end
      @(negedge clk);
      data_req = 1'b0;
      @(negedge clk);
      rob_clear = 1'b1;
      @(negedge clk);
      rob_clear = 1'b0;
      wait_mc_done(n);
      @(negedge clk); #1;
      tests++; if ({data_done, data_rdata} !== {1'b0, 32'h0}) begin fails++; $display("FAIL flush_load_suppress got=%b/%h exp=0/0", data_done, data_rdata); end
      data_req = 1'b1; data_addr = 32'h3004; mc_resp = 32'hBB;
      #1;
      tests++; if (data_grant !== 1'b1) begin fails++; $display("FAIL flush_next_grant got=%b exp=1", data_grant); end
      @(negedge clk);
      data_req = 1'b0;
      wait_mc_done(n);
      @(negedge clk); #1;
      tests++; if ({data_done, data_rdata} !== {1'b1, 32'hBB}) begin fails++; $display("FAIL flush_next_done got=%b/%h exp=1/bb", data_done, data_rdata); end
      data_req = 1'b1; data_addr = 32'h3008; mc_resp = 32'hCC;
      @(negedge clk);
      data_req = 1'b0;
      wait_mc_done(n);
      rob_clear = 1'b1;
      @(negedge clk);
      rob_clear = 1'b0;
      #1;
      tests++; if ({data_done, data_rdata} !== {1'b0, 32'hBB}) begin fails++; $display("FAIL flush_with_done got=%b/%h exp=0/bb", data_done, data_rdata); end
   endtask

   task automatic test_rob_clear_store();
      int n;
      do_reset();
      data_req = 1'b1; data_is_write = 1'b1; data_addr = 32'h30000; data_wdata = 32'hDEADBEEF; data_type = 3'b010;
      #1;
      tests++; if (data_grant !== 1'b1) begin fails++; $display("FAIL store_grant got=%b exp=1", data_grant); end
      @(negedge clk);
      data_req = 1'b0; data_wdata = 32'h0; data_is_write = 1'b0;
      #1;
      tests++; if ({mc_is_write, mc_addr} !== {1'b1, 32'h30000}) begin fails++; $display("FAIL store_fields got=%b/%h exp=1/30000", mc_is_write, mc_addr); end
      @(negedge clk);
      rob_clear = 1'b1;
      @(negedge clk);
      rob_clear = 1'b0;
      #1;
      tests++; if (mc_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL store_wdata got=%h exp=deadbeef", mc_wdata); end
      wait_mc_done(n);
      @(negedge clk); #1;
      tests++; if (data_done !== 1'b1) begin fails++; $display("FAIL store_done got=%b exp=1", data_done); end
   endtask

   task automatic test_pause_reset();
      int seen;
      do_reset();
      mc_resp = 32'h77;
      inst_req = 1'b1; inst_addr = 32'h400;
      #1;
      tests++; if (inst_grant !== 1'b1) begin fails++; $display("FAIL pause_grant got=%b exp=1", inst_grant); end
      @(negedge clk);
      inst_req = 1'b0; rdy_in = 1'b0;
      #1;
      tests++; if (mc_start !== 1'b1) begin fails++; $display("FAIL pause_start got=%b exp=1", mc_start); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         tests++; if ({mc_start, mc_busy} !== 2'b10) begin fails++; $display("FAIL pause_hold%0d got=%b exp=10", i, {mc_start, mc_busy}); end
      end
      rdy_in = 1'b1;
      @(negedge clk); #1;
      tests++; if ({mc_start, mc_busy, mc_addr} !== {2'b01, 32'h400}) begin fails++; $display("FAIL pause_resume got=%b/%h exp=01/400", {mc_start, mc_busy}, mc_addr); end
      @(negedge clk); #1;
      tests++; if (mc_start !== 1'b0) begin fails++; $display("FAIL pause_no_restrobe got=%b exp=0", mc_start); end
      rst_in = 1'b1;
      @(negedge clk);
      rst_in = 1'b0;
      #1;
      tests++; if ({mc_start, mc_is_write, inst_done, data_done, mc_type} !== 7'b0) begin fails++; $display("FAIL midreset_ctrl got=%b exp=0", {mc_start, mc_is_write, inst_done, data_done, mc_type}); end
      tests++; if ({mc_addr, inst_data} !== 64'h0) begin fails++; $display("FAIL midreset_data got=%h exp=0", {mc_addr, inst_data}); end
      tests++; if (dut.state_q !== ST_IDLE) begin fails++; $display("FAIL midreset_state got=%0d exp=IDLE", dut.state_q); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (inst_done || data_done) seen++;
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_inst_only();
      test_data_first();
      test_starvation();
      test_rob_clear_load();
      test_rob_clear_store();
      test_pause_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
